// File: rtl/game_flow_ctrl_if.sv
// Frame-rate signal bundle between the game sequencer and its input and delegate blocks.
interface game_flow_ctrl_if;
  logic        jumpBtn;
  logic        duckBtn;
  logic        collision;
  logic [1:0]  gameState;
  logic        jump;
  logic        duck;
  logic        newGame;
  logic [13:0] score;
  logic [2:0]  speedLevel;
  logic [13:0] hiScore;

  modport master (
    output jumpBtn, duckBtn, collision,
    input  gameState, jump, duck, newGame, score, speedLevel, hiScore
  );

  modport slave (
    input  jumpBtn, duckBtn, collision,
    output gameState, jump, duck, newGame, score, speedLevel, hiScore
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/RUN/DEAD flow, per-frame jump/duck/newGame commands, score and speed schedule.
// Optional best-score register enabled by defining GAME_HISCORE_EN.
module game_flow_ctrl #(
  parameter int unsigned SCORE_DIV    = 6,
  parameter int unsigned SPEED_STEP   = 100,
  parameter int unsigned MAX_SPEED    = 7,
  parameter int unsigned DEAD_HOLDOFF = 30
) (
  input logic            FrameClk,
  input logic            rst,
  game_flow_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b10,
    DEAD = 2'b01,
    BAD  = 2'b11
  } state_t;

  localparam logic [15:0] DivLast   = 16'(SCORE_DIV - 1);
  localparam logic [15:0] StepLast  = 16'(SPEED_STEP - 1);
  localparam logic [15:0] HoldInit  = 16'(DEAD_HOLDOFF);
  localparam logic [2:0]  SpeedMax  = 3'(MAX_SPEED);
  localparam logic [13:0] ScoreMax  = 14'd9999;

  state_t      state, stateN;
  logic        jPrev;
  logic        jEdge;
  logic        jumpQ, jumpN;
  logic        duckQ, duckN;
  logic        newGameQ, newGameN;
  logic [13:0] scoreQ, scoreN;
  logic [2:0]  speedQ, speedN;
  logic [15:0] divCnt, divN;
  logic [15:0] stepCnt, stepN;
  logic [15:0] holdCnt, holdN;
`ifdef GAME_HISCORE_EN
  logic [13:0] hiQ, hiN;
`endif

  assign jEdge = io.jumpBtn & ~jPrev;

  always_comb begin
    stateN   = state;
    jumpN    = 1'b0;
    duckN    = 1'b0;
    newGameN = 1'b0;
    scoreN   = scoreQ;
    speedN   = speedQ;
    divN     = divCnt;
    stepN    = stepCnt;
    holdN    = holdCnt;
`ifdef GAME_HISCORE_EN
    hiN      = hiQ;
`endif
    case (state)
      IDLE: begin
        if (jEdge) begin
          stateN   = RUN;
          newGameN = 1'b1;
          scoreN   = '0;
          speedN   = '0;
          divN     = '0;
          stepN    = '0;
        end
      end
      RUN: begin
        // Collision wins the frame: no score step, no jump.
        if (io.collision) begin
          stateN = DEAD;
          holdN  = HoldInit;
`ifdef GAME_HISCORE_EN
          if (scoreQ > hiQ) hiN = scoreQ;
`endif
        end else begin
          jumpN = jEdge;
          duckN = io.duckBtn & ~io.jumpBtn;
          if (divCnt == DivLast) begin
            divN = '0;
            if (scoreQ != ScoreMax) begin
              scoreN = scoreQ + 14'd1;
              if (stepCnt == StepLast) begin
                stepN = '0;
                if (speedQ != SpeedMax) speedN = speedQ + 3'd1;
              end else begin
                stepN = stepCnt + 16'd1;
              end
            end
          end else begin
            divN = divCnt + 16'd1;
          end
        end
      end
      DEAD: begin
        if (holdCnt != '0) begin
          holdN = holdCnt - 16'd1;
        end else if (jEdge) begin
          stateN   = RUN;
          newGameN = 1'b1;
          scoreN   = '0;
          speedN   = '0;
          divN     = '0;
          stepN    = '0;
        end
      end
      default: begin
        stateN = IDLE;
        scoreN = '0;
        speedN = '0;
        divN   = '0;
        stepN  = '0;
        holdN  = '0;
`ifdef GAME_HISCORE_EN
        hiN    = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge FrameClk) begin
    if (rst) begin
      state    <= IDLE;
      jPrev    <= 1'b1;
      jumpQ    <= 1'b0;
      duckQ    <= 1'b0;
      newGameQ <= 1'b0;
      scoreQ   <= '0;
      speedQ   <= '0;
      divCnt   <= '0;
      stepCnt  <= '0;
      holdCnt  <= '0;
`ifdef GAME_HISCORE_EN
      hiQ      <= '0;
`endif
    end else begin
      state    <= stateN;
      jPrev    <= io.jumpBtn;
      jumpQ    <= jumpN;
      duckQ    <= duckN;
      newGameQ <= newGameN;
      scoreQ   <= scoreN;
      speedQ   <= speedN;
      divCnt   <= divN;
      stepCnt  <= stepN;
      holdCnt  <= holdN;
`ifdef GAME_HISCORE_EN
      hiQ      <= hiN;
`endif
    end
  end

  assign io.gameState  = (state == BAD) ? IDLE : state;
  assign io.jump       = jumpQ;
  assign io.duck       = duckQ;
  assign io.newGame    = newGameQ;
  assign io.score      = scoreQ;
  assign io.speedLevel = speedQ;
`ifdef GAME_HISCORE_EN
  assign io.hiScore    = hiQ;
`else
  assign io.hiScore    = '0;
`endif

endmodule
